// File: rtl/exe_ctrl_pkg.sv
// Shared types, instruction field map and widths for the exe_ctrl sequencer.
// Optional macro EXE_CTRL_STEP_EN adds the PAUSE state used for single-stepping.
package exe_ctrl_pkg;

    localparam int INSTR_W = 28;
    localparam int DATA_W  = 10;

    localparam int CLS_HI  = 27;
    localparam int CLS_LO  = 26;
    localparam int OPER_HI = 25;
    localparam int OPER_LO = 23;
    localparam int IMM_BIT = 22;
    localparam int MASK_HI = 25;
    localparam int MASK_LO = 22;
    localparam int RD_HI   = 21;
    localparam int RD_LO   = 18;
    localparam int RS0_HI  = 17;
    localparam int RS0_LO  = 14;
    localparam int RS1_HI  = 13;
    localparam int RS1_LO  = 10;
    localparam int DATA_HI = 9;
    localparam int DATA_LO = 0;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'b00,
        CLS_BR   = 2'b01,
        CLS_HALT = 2'b10,
        CLS_NOP  = 2'b11
    } cls_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WB,
        DONE
`ifdef EXE_CTRL_STEP_EN
        , PAUSE
`endif
    } state_t;

endpackage

// File: rtl/exe_ctrl_decode.sv
// Combinational instruction field extraction and branch-taken evaluation
// against the latched flag register.
module exe_ctrl_decode
    import exe_ctrl_pkg::*;
(
    input  logic [INSTR_W-1:0]       instr,
    input  logic [3:0]               flag,
    output cls_t                     cls,
    output logic [2:0]               oper,
    output logic                     imm,
    output logic [3:0]               rd,
    output logic [3:0]               rs0,
    output logic [3:0]               rs1,
    output logic signed [DATA_W-1:0] data,
    output logic                     taken
);

    logic [3:0] mask;

    assign cls  = cls_t'(instr[CLS_HI:CLS_LO]);
    assign oper = instr[OPER_HI:OPER_LO];
    assign imm  = instr[IMM_BIT];
    assign rd   = instr[RD_HI:RD_LO];
    assign rs0  = instr[RS0_HI:RS0_LO];
    assign rs1  = instr[RS1_HI:RS1_LO];
    assign data = instr[DATA_HI:DATA_LO];
    assign mask = instr[MASK_HI:MASK_LO];

    // A zero mask is an unconditional branch.
    assign taken = (mask == '0) || ((mask & flag) != '0);

endmodule

// File: rtl/exe_ctrl.sv
// Multi-cycle fetch/decode/execute/write-back sequencer driving the exe stage.
// Define EXE_CTRL_STEP_EN to add the i_step port and the PAUSE state.
module exe_ctrl #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = exe_ctrl_pkg::INSTR_W
) (
    input  logic                                   i_clk,
    input  logic                                   i_rsn,
    input  logic                                   i_start,
`ifdef EXE_CTRL_STEP_EN
    input  logic                                   i_step,
`endif
    input  logic [INSTR_W-1:0]                     i_instr,
    output logic [PC_W-1:0]                        o_pc,
    input  logic signed [exe_ctrl_pkg::DATA_W-1:0] i_result,
    input  logic [3:0]                             i_flag,
    output logic [2:0]                             o_oper,
    output logic [3:0]                             o_reg0,
    output logic [3:0]                             o_reg1,
    output logic [3:0]                             o_reg2,
    output logic                                   o_imm,
    output logic signed [exe_ctrl_pkg::DATA_W-1:0] o_data,
    output logic signed [exe_ctrl_pkg::DATA_W-1:0] o_wdata,
    output logic                                   o_we,
    output logic                                   o_busy,
    output logic                                   o_done
);
    import exe_ctrl_pkg::*;

`ifdef EXE_CTRL_STEP_EN
    localparam state_t RESUME = PAUSE;
`else
    localparam state_t RESUME = FETCH;
`endif

    state_t                    state;
    logic [INSTR_W-1:0]        ir;
    logic [INSTR_W-1:0]        dec_src;
    logic [3:0]                flag;
    cls_t                      cls;
    logic [2:0]                oper;
    logic                      imm;
    logic [3:0]                rd;
    logic [3:0]                rs0;
    logic [3:0]                rs1;
    logic signed [DATA_W-1:0]  data;
    logic                      taken;

    // Operand outputs are registered at the DECODE edge straight from ROM data,
    // so they are already stable throughout EXEC; afterwards the decoder sees IR.
    assign dec_src = (state == DECODE) ? i_instr : ir;

    exe_ctrl_decode u_decode (
        .instr (dec_src),
        .flag  (flag),
        .cls   (cls),
        .oper  (oper),
        .imm   (imm),
        .rd    (rd),
        .rs0   (rs0),
        .rs1   (rs1),
        .data  (data),
        .taken (taken)
    );

    // o_pc is the program counter and o_wdata is the result register.
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            state   <= IDLE;
            o_pc    <= '0;
            ir      <= '0;
            flag    <= '0;
            o_wdata <= '0;
            o_oper  <= '0;
            o_reg0  <= '0;
            o_reg1  <= '0;
            o_reg2  <= '0;
            o_imm   <= 1'b0;
            o_data  <= '0;
            o_we    <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        o_pc   <= '0;
                        state  <= FETCH;
                        o_busy <= 1'b1;
                        o_done <= 1'b0;
                    end
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    ir    <= i_instr;
                    state <= EXEC;
                    if (cls == CLS_ALU) begin
                        o_oper <= oper;
                        o_reg0 <= rs0;
                        o_reg1 <= rs1;
                        o_imm  <= imm;
                        o_data <= data;
                    end
                end
                EXEC: begin
                    case (cls)
                        CLS_ALU: begin
                            o_wdata <= i_result;
                            flag    <= i_flag;
                            o_reg2  <= rd;
                            o_we    <= 1'b1;
                            state   <= WB;
                        end
                        CLS_BR: begin
                            o_pc  <= taken ? ir[PC_W-1:0] : o_pc + PC_W'(1);
                            state <= RESUME;
                        end
                        CLS_HALT: begin
                            state  <= DONE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end
                        CLS_NOP: begin
                            o_pc  <= o_pc + PC_W'(1);
                            state <= RESUME;
                        end
                    endcase
                end
                WB: begin
                    o_pc  <= o_pc + PC_W'(1);
                    state <= RESUME;
                end
`ifdef EXE_CTRL_STEP_EN
                PAUSE: begin
                    if (i_step) state <= FETCH;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_ctrl.sv
// Self-checking bench for exe_ctrl: ROM and exe stage models plus an
// instruction-level reference model with per-instruction cycle costs.
module tb_exe_ctrl;

    localparam int MAX_INS = 400;
    localparam int NCYC    = 4096;
`ifdef EXE_CTRL_STEP_EN
    localparam int PAUSE_CYC = 1;
`else
    localparam int PAUSE_CYC = 0;
`endif

    logic              clk = 1'b0;
    logic              rsn = 1'b1;
    logic              start = 1'b0;
`ifdef EXE_CTRL_STEP_EN
    logic              step = 1'b1;
`endif
    logic [27:0]       instr;
    logic [7:0]        pc;
    logic signed [9:0] result;
    logic [3:0]        flag;
    logic [2:0]        oper;
    logic [3:0]        reg0, reg1, reg2;
    logic              imm, we, busy, done;
    logic signed [9:0] data, wdata;

    exe_ctrl #(.PC_W(8)) dut (
        .i_clk    (clk),
        .i_rsn    (rsn),
        .i_start  (start),
`ifdef EXE_CTRL_STEP_EN
        .i_step   (step),
`endif
        .i_instr  (instr),
        .o_pc     (pc),
        .i_result (result),
        .i_flag   (flag),
        .o_oper   (oper),
        .o_reg0   (reg0),
        .o_reg1   (reg1),
        .o_reg2   (reg2),
        .o_imm    (imm),
        .o_data   (data),
        .o_wdata  (wdata),
        .o_we     (we),
        .o_busy   (busy),
        .o_done   (done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with one cycle of read latency.
    logic [27:0] rom [256];
    always @(posedge clk) instr <= rom[pc];

    // exe stage: register file plus combinational ALU with bench-defined ops.
    logic signed [9:0] regs [16];
    always @(posedge clk or negedge rsn) begin
        if (!rsn) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (we) begin
            regs[reg2] <= wdata;
        end
    end

    function automatic logic signed [9:0] alu(input logic [2:0] op, input logic signed [9:0] a, input logic signed [9:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return b;
            3'd6:    return a;
            default: return ~a;
        endcase
    endfunction

    function automatic logic [3:0] flags_of(input logic signed [9:0] r);
        return {r[9] ^ r[8], r[0], r[9], r == 10'sd0};
    endfunction

    always_comb begin
        result = alu(oper, regs[reg0], imm ? data : regs[reg1]);
        flag   = flags_of(result);
    end

    function automatic logic [27:0] i_alu(input int op, input int im, input int rd, input int rs0, input int rs1, input int d);
        return {2'b00, op[2:0], im[0], rd[3:0], rs0[3:0], rs1[3:0], d[9:0]};
    endfunction

    function automatic logic [27:0] i_br(input int mask, input int tgt);
        return {2'b01, mask[3:0], 12'd0, tgt[9:0]};
    endfunction

    localparam logic [27:0] I_HALT = {2'b10, 26'd0};
    localparam logic [27:0] I_NOP  = {2'b11, 26'd0};

    int ntests = 0;
    int nfail  = 0;
    int cur    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cur, obs, exp);
        end
    endtask

    // Reference model state and expected per-cycle observations.
    logic signed [9:0] m_regs [16];
    logic [3:0]        m_flag;
    bit                e_we  [NCYC];
    logic [3:0]        e_reg [NCYC];
    logic signed [9:0] e_wd  [NCYC];
    bit                e_f   [NCYC];
    logic [7:0]        e_pc  [NCYC];
    int                e_total;
    bit                e_halt;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_flag = '0;
    endtask

    // Instruction-level execution: ALU costs 4 cycles, others 3 (+1 when paused between).
    task automatic iss(input logic [27:0] first0);
        logic [7:0]        p;
        logic [27:0]       ins;
        logic signed [9:0] a, b, r;
        int                c;
        for (int i = 0; i < NCYC; i++) begin
            e_we[i] = 1'b0; e_f[i] = 1'b0; e_reg[i] = '0; e_wd[i] = '0; e_pc[i] = '0;
        end
        p = '0; c = 0; e_halt = 1'b0;
        for (int k = 0; k < MAX_INS && !e_halt; k++) begin
            ins = (k == 0) ? first0 : rom[p];
            e_f[c]  = 1'b1;
            e_pc[c] = p;
            case (ins[27:26])
                2'b00: begin
                    a = m_regs[ins[17:14]];
                    b = ins[22] ? ins[9:0] : m_regs[ins[13:10]];
                    r = alu(ins[25:23], a, b);
                    m_flag = flags_of(r);
                    e_we[c+3]  = 1'b1;
                    e_reg[c+3] = ins[21:18];
                    e_wd[c+3]  = r;
                    m_regs[ins[21:18]] = r;
                    p = p + 8'd1;
                    c = c + 4 + PAUSE_CYC;
                end
                2'b01: begin
                    if (ins[25:22] == 4'd0 || (ins[25:22] & m_flag) != 4'd0) p = ins[7:0];
                    else p = p + 8'd1;
                    c = c + 3 + PAUSE_CYC;
                end
                2'b10: begin
                    e_halt = 1'b1;
                    c = c + 3;
                end
                default: begin
                    p = p + 8'd1;
                    c = c + 3 + PAUSE_CYC;
                end
            endcase
        end
        e_total = c;
    endtask

    task automatic do_reset();
        @(negedge clk) rsn = 1'b0;
        @(negedge clk) rsn = 1'b1;
        model_reset();
    endtask

    // first0 is what ROM[0] holds for the first fetch only; ROM[0] is restored afterwards.
    task automatic run_prog(input logic [27:0] first0);
        logic [27:0] final0;
        int          last;
        final0 = rom[0];
        iss(first0);
        rom[0] = first0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        last = e_halt ? e_total : e_total - 1;
        for (int c = 0; c <= last; c++) begin
            if (c > 0) @(negedge clk);
            cur = c;
            if (c == 2) rom[0] = final0;
            chk("busy", 32'(busy), 32'(c < e_total || !e_halt));
            chk("done", 32'(done), 32'(e_halt && c >= e_total));
            chk("we", 32'(we), 32'(e_we[c]));
            if (e_we[c]) begin
                chk("reg2", 32'(reg2), 32'(e_reg[c]));
                chk("wdata", 32'(wdata), 32'(e_wd[c]));
            end
            if (e_f[c]) chk("pc", 32'(pc), 32'(e_pc[c]));
        end
        if (!e_halt) do_reset();
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = I_HALT;
        model_reset();

        // Reset state
        #1 rsn = 1'b0;
        repeat (2) @(negedge clk);
        cur = 0;
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_oper", 32'(oper), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        rsn = 1'b1;

        // R1 = R0 + 37, then halt
        rom[0] = i_alu(0, 1, 1, 0, 0, 37);
        rom[1] = I_HALT;
        run_prog(rom[0]);

        // Restart from DONE: R3 = R1 + 5 (42), done 7 cycles after start
        rom[0] = i_alu(0, 1, 3, 1, 0, 5);
        run_prog(rom[0]);

        // Taken branch: R4 = R1 - R1 sets flags 0001, mask 0001 -> pc 0x10
        rom[0]  = i_alu(1, 0, 4, 1, 1, 0);
        rom[1]  = i_br(1, 16);
        rom[2]  = I_HALT;
        rom[16] = I_HALT;
        run_prog(rom[0]);

        // Untaken branch: R5 = R0 + 2 gives flags 0000, mask 0010 -> pc 2
        rom[0]  = i_alu(0, 1, 5, 0, 0, 2);
        rom[1]  = i_br(2, 32);
        rom[32] = I_HALT;
        run_prog(rom[0]);

        // PC wrap: 256 nops from address 0, then halt fetched at 0 again
        for (int i = 0; i < 256; i++) rom[i] = I_NOP;
        rom[0] = I_HALT;
        run_prog(I_NOP);

        // Reset during write-back
        rom[0] = I_NOP;
        rom[1] = I_NOP;
        rom[2] = i_alu(0, 1, 6, 0, 0, 9);
        rom[3] = I_HALT;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 30 && !we; i++) @(negedge clk);
        cur = -1;
        chk("wb_reached", 32'(we), 32'd1);
        chk("wb_pc", 32'(pc), 32'd2);
        rsn = 1'b0;
        #1;
        chk("rstwb_we", 32'(we), 32'd0);
        chk("rstwb_pc", 32'(pc), 32'd0);
        chk("rstwb_busy", 32'(busy), 32'd0);
        @(negedge clk) rsn = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rstwb_idle_busy", 32'(busy), 32'd0);
        chk("rstwb_idle_done", 32'(done), 32'd0);

        // Random programs in the first 24 words
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 256; i++) rom[i] = I_HALT;
            for (int i = 0; i < 24; i++) begin
                int sel;
                sel = int'($urandom_range(0, 9));
                if (sel <= 5)
                    rom[i] = i_alu(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                                   int'($urandom_range(0, 15)), int'($urandom_range(0, 1023)));
                else if (sel <= 7)
                    rom[i] = i_br(int'($urandom_range(0, 15)), int'($urandom_range(0, 24)));
                else if (sel == 8)
                    rom[i] = I_NOP;
                else
                    rom[i] = I_HALT;
            end
            run_prog(rom[0]);
        end

`ifdef EXE_CTRL_STEP_EN
        // Single-step: stall in PAUSE, one i_step pulse fetches the next instruction
        do_reset();
        for (int i = 0; i < 256; i++) rom[i] = I_HALT;
        rom[0] = I_NOP;
        rom[1] = I_NOP;
        step = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            cur = 3 + i;
            chk("pause_busy", 32'(busy), 32'd1);
            chk("pause_pc", 32'(pc), 32'd1);
            if (i < 9) @(negedge clk);
        end
        step = 1'b1;
        @(negedge clk) step = 1'b0;
        chk("step_fetch_pc", 32'(pc), 32'd1);
        repeat (3) @(negedge clk);
        chk("step_pause2_pc", 32'(pc), 32'd2);
        @(negedge clk);
        chk("step_hold_pc", 32'(pc), 32'd2);
        chk("step_hold_busy", 32'(busy), 32'd1);
        step = 1'b1;
        for (int i = 0; i < 10 && !done; i++) @(negedge clk);
        chk("step_done", 32'(done), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/exe_ctrl.md
# exe_ctrl

Multi-cycle instruction sequencer that drives the `exe` stage (ALU plus register file). It fetches 28-bit instructions from a synchronous program ROM and decodes them. It presents the operator, register indices and immediate to `exe`, latches the ALU result and flags, and performs register write-back. It also handles conditional branches and halt, so it is the control unit of the small CPU datapath.

## Interface
- `PC_W`, default 8: program counter width.
- `INSTR_W`, default 28: instruction width (fixed field map; do not change).
- `i_clk` in 1: clock, rising edge.
- `i_rsn` in 1: asynchronous active-low reset.
- `i_start` in 1: start execution from PC 0. Sampled only in IDLE or DONE.
- `i_instr` in 28: ROM read data, valid one cycle after `o_pc` changes.
- `o_pc` out PC_W: ROM address.
- `i_result` in 10 (signed): `exe` `o_data`.
- `i_flag` in 4: `exe` `o_flag`.
- `o_oper` out 3: drives `exe` `i_oper`.
- `o_reg0`, `o_reg1` out 4 each: source register indices.
- `o_reg2` out 4: write register index.
- `o_imm` out 1: drives `exe` `i_imm`.
- `o_data` out 10 (signed): immediate, drives `exe` `i_data`.
- `o_wdata` out 10 (signed): write-back data, drives `exe` `i_data2`.
- `o_we` out 1: register-file write enable. The register file writes only when it is high.
- `o_busy` out 1: high in every state except IDLE and DONE.
- `o_done` out 1: high in DONE.
- `i_step` in 1: only present with `EXE_CTRL_STEP_EN`.

## Operation
- Instruction fields:
  - [27:26] class: 00 ALU, 01 branch, 10 halt, 11 nop.
  - [25:23] oper.
  - [22] imm.
  - [21:18] rd.
  - [17:14] rs0.
  - [13:10] rs1.
  - [9:0] immediate.
- States: IDLE, FETCH, DECODE, EXEC, WB, DONE, and PAUSE (PAUSE exists only with the macro).
- IDLE: on `i_start`, set pc=0 and go to FETCH.
- FETCH: `o_pc`=pc. Go to DECODE.
- DECODE: latch `i_instr` into IR. Go to EXEC.
- EXEC, ALU class:
  - Drive `o_oper`/`o_reg0`/`o_reg1`/`o_imm`/`o_data` from IR.
  - Capture `i_result` into the result register and `i_flag` into the flag register.
  - Go to WB.
- EXEC, branch class:
  - mask = IR[25:22].
  - The branch is taken if mask==0, or if (mask & flag register)!=0.
  - If taken, pc=IR[PC_W-1:0]; otherwise pc=pc+1.
  - Go to FETCH. Flags are unchanged.
- EXEC, halt class: go to DONE.
- EXEC, nop class: pc=pc+1, go to FETCH.
- WB: `o_we`=1, `o_reg2`=rd, `o_wdata`=result register, pc=pc+1. Go to FETCH.
- DONE: hold pc. On `i_start`, restart from pc 0.
- `i_start` is ignored while `o_busy` is high.
- PC wraps modulo 2^PC_W (255 → 0). No overflow flag.
- Outside EXEC, `o_oper`/`o_reg*`/`o_imm`/`o_data` hold their last EXEC values. `o_we` is 0 in every state except WB.
- `rd` is taken only from IR; `o_reg2` is don't-care while `o_we`=0.

## Timing
- Reset, asynchronous and immediate from any state:
  - state=IDLE.
  - pc, IR, result register, flag register all 0.
  - All outputs 0.
- ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
- Branch or nop: 3 cycles.
- Halt: 3 cycles, then `o_done` is high from the next cycle.
- The ROM has 1-cycle read latency. `i_instr` is sampled on the DECODE edge.
- `i_result`/`i_flag` are combinational from `exe` and sampled at the end of EXEC.
- Register writes commit on the rising edge that ends WB. The next instruction's EXEC reads the updated value.

## Configuration
- Macro `EXE_CTRL_STEP_EN`.
- When defined:
  - Port `i_step` exists.
  - After WB, branch or nop completes, the FSM enters PAUSE instead of FETCH, holding the already-updated pc.
  - A single-cycle `i_step` high moves PAUSE → FETCH.
  - `o_busy` stays 1 in PAUSE.
- When undefined: no port and no PAUSE state. Execution runs freely.

## Structure
- Package `exe_ctrl_pkg` holds:
  - The state enum.
  - Class codes (CLS_ALU, CLS_BR, CLS_HALT, CLS_NOP).
  - Field bit positions.
  - INSTR_W and the 10-bit data width constant.
- Sub-module `exe_ctrl_decode` is combinational. It does field extraction and branch-taken evaluation from IR and the flag register.

## Test plan
- Reset mid-WB: assert `i_rsn`=0 while `o_we`=1 → `o_we`, `o_pc`, `o_busy` go to 0 immediately. After release the FSM is in IDLE.
- ALU with immediate: ROM[0]={ALU, oper=add, imm=1, rd=3, rs0=1, data=5}, followed by halt → exactly one `o_we` pulse with `o_reg2`=3 and `o_wdata`=R1+5. `o_done` rises 7 cycles after start.
- Taken branch: flags capture 4'b0001, then ROM[1]={BR, mask=0001, target=8'h10} → the next `o_pc` is 8'h10.
- Untaken branch: flags capture 0, mask=0010 → the next `o_pc` is 2.
- PC wrap: 256 nops, then halt at 0 → `o_pc` goes 255 → 0 and DONE is reached.
- With `EXE_CTRL_STEP_EN`: the FSM stalls in PAUSE with `o_busy`=1 and `o_pc` unchanged for 10 cycles. One `i_step` pulse → FETCH of the next instruction.
